// File: rtl/result_display_seq.sv
// Sequenced single-digit display for the regression results: snapshots intercept,
// slope and det on result_valid and plays them as a looping slideshow on one 7-seg digit.
module result_display_seq #(
    parameter int unsigned RESULT_WIDTH = 14,
    parameter int unsigned DWELL_CYCLES = 5000000,
    parameter int unsigned GAP_CYCLES   = 500000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           result_valid,
    input  logic signed [RESULT_WIDTH-1:0] intercept,
    input  logic signed [RESULT_WIDTH-1:0] slope,
    input  logic signed [RESULT_WIDTH-1:0] det,
    input  logic                           error_det,
    input  logic                           error_values,
    output logic [6:0]                     seg,
    output logic                           dp,
    output logic                           busy,
    output logic [1:0]                     field_idx,
    output logic                           frame_done
);

    localparam int unsigned CntMax = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]         DwellLast = CntW'(DWELL_CYCLES - 1);
    localparam logic [CntW-1:0]         GapLast   = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0]         CntOne    = CntW'(1);
    localparam logic [RESULT_WIDTH:0]   Lim99     = (RESULT_WIDTH + 1)'(99);

    localparam logic [6:0] SegB     = 7'h7C;
    localparam logic [6:0] SegL     = 7'h38;
    localparam logic [6:0] SegD     = 7'h5E;
    localparam logic [6:0] SegMinus = 7'h40;
    localparam logic [6:0] SegE     = 7'h79;
    localparam logic [6:0] SegOne   = 7'h06;
    localparam logic [6:0] SegTwo   = 7'h5B;

    typedef enum logic [1:0] {StIdle, StShow, StGap, StErr} state_e;

    state_e                          state_q, state_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [3:0]                      idx_q, idx_d;
    logic signed [RESULT_WIDTH-1:0]  icpt_q, icpt_d;
    logic signed [RESULT_WIDTH-1:0]  slope_q, slope_d;
    logic signed [RESULT_WIDTH-1:0]  det_q, det_d;
    logic                            edet_q, edet_d;
    logic                            frame_d;

    logic [6:0]                      seg_q, seg_d;
    logic                            dp_q, dp_d;
    logic                            busy_q, busy_d;
    logic [1:0]                      field_q, field_d;
    logic                            frame_q;

    // Symbol decode scratch.
    logic [1:0]                      field_c, pos_c;
    logic                            banner_c;
    logic signed [RESULT_WIDTH-1:0]  val_c;
    logic signed [RESULT_WIDTH:0]    val_ext;
    logic [RESULT_WIDTH:0]           mag_c;
    logic [6:0]                      mag7;
    logic                            big_c;
    logic [3:0]                      tens_c, ones_c;
    logic [6:0]                      sym_c;
    logic                            sym_dp_c;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            icpt_q  <= '0;
            slope_q <= '0;
            det_q   <= '0;
            edet_q  <= 1'b0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
            field_q <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            icpt_q  <= icpt_d;
            slope_q <= slope_d;
            det_q   <= det_d;
            edet_q  <= edet_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
            field_q <= field_d;
            frame_q <= frame_d;
        end
    end

    // Next state: ERR is sticky, error_values beats capture, capture beats dwell/gap stepping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        icpt_d  = icpt_q;
        slope_d = slope_q;
        det_d   = det_q;
        edet_d  = edet_q;
        frame_d = 1'b0;
        if (state_q == StErr) begin
            // idx bit 0 alternates between the 'E' and '2' phases.
            if (cnt_q == DwellLast) begin
                cnt_d = '0;
                idx_d = {3'b000, ~idx_q[0]};
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (error_values) begin
            state_d = StErr;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (result_valid) begin
            icpt_d  = intercept;
            slope_d = slope;
            det_d   = det;
            edet_d  = error_det;
            state_d = StShow;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StShow: begin
                    if (cnt_q == DwellLast) begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                        if (idx_q == (edet_q ? 4'd5 : 4'd11)) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from next-state values so the first symbol lands right after capture.
    always_comb begin
        banner_c = 1'b0;
        if (edet_d) begin
            if (idx_d < 4'd2) begin
                banner_c = 1'b1;
                field_c  = 2'd3;
                pos_c    = idx_d[1:0];
            end else begin
                field_c = 2'd2;
                pos_c   = 2'(idx_d - 4'd2);
            end
        end else begin
            field_c = idx_d[3:2];
            pos_c   = idx_d[1:0];
        end

        unique case (field_c)
            2'd0:    val_c = icpt_d;
            2'd1:    val_c = slope_d;
            default: val_c = det_d;
        endcase

        // One extra bit so the most negative value has a representable magnitude.
        val_ext = {val_c[RESULT_WIDTH-1], val_c};
        mag_c   = val_c[RESULT_WIDTH-1] ? $unsigned(-val_ext) : $unsigned(val_ext);
        big_c   = mag_c > Lim99;
        mag7    = mag_c[6:0];
        tens_c  = big_c ? 4'd9 : 4'(mag7 / 7'd10);
        ones_c  = big_c ? 4'd9 : 4'(mag7 % 7'd10);

        if (banner_c) begin
            sym_c = pos_c[0] ? SegOne : SegE;
        end else begin
            unique case (pos_c)
                2'd0:    sym_c = (field_c == 2'd0) ? SegB : (field_c == 2'd1) ? SegL : SegD;
                2'd1:    sym_c = val_c[RESULT_WIDTH-1] ? SegMinus : 7'h00;
                2'd2:    sym_c = digit_seg(tens_c);
                default: sym_c = digit_seg(ones_c);
            endcase
        end
        sym_dp_c = !banner_c && pos_c[1] && big_c;

        seg_d   = '0;
        dp_d    = 1'b0;
        busy_d  = 1'b1;
        field_d = field_c;
        unique case (state_d)
            StShow: begin
                seg_d = sym_c;
                dp_d  = sym_dp_c;
            end
            StGap: ;
            StErr: begin
                seg_d   = idx_d[0] ? SegTwo : SegE;
                field_d = 2'd3;
            end
            default: begin
                busy_d  = 1'b0;
                field_d = 2'd0;
            end
        endcase
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign busy       = busy_q;
    assign field_idx  = field_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_result_display_seq.sv
// Bench for result_display_seq: symbol lists are built from the display rules and
// expanded into a per-cycle expected trace (dwell, gap, frame wrap).
module tb_result_display_seq;

    localparam int W = 14;
    localparam int D = 4;
    localparam int G = 1;
    localparam int P = D + G;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                result_valid = 1'b0;
    logic signed [W-1:0] intercept = '0;
    logic signed [W-1:0] slope = '0;
    logic signed [W-1:0] det = '0;
    logic                error_det = 1'b0;
    logic                error_values = 1'b0;
    logic [6:0]          seg;
    logic                dp;
    logic                busy;
    logic [1:0]          field_idx;
    logic                frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [1:0] fld;
    } sym_t;

    sym_t syms[$];

    result_display_seq #(
        .RESULT_WIDTH (W),
        .DWELL_CYCLES (D),
        .GAP_CYCLES   (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .intercept    (intercept),
        .slope        (slope),
        .det          (det),
        .error_det    (error_det),
        .error_values (error_values),
        .seg          (seg),
        .dp           (dp),
        .busy         (busy),
        .field_idx    (field_idx),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] s, input logic d,
                             input logic b, input logic [1:0] f, input logic fd);
        chk({tag, " seg"}, {1'b0, seg}, {1'b0, s});
        chk({tag, " dp"}, {7'd0, dp}, {7'd0, d});
        chk({tag, " busy"}, {7'd0, busy}, {7'd0, b});
        chk({tag, " field"}, {6'd0, field_idx}, {6'd0, f});
        chk({tag, " frame_done"}, {7'd0, frame_done}, {7'd0, fd});
    endtask

    function automatic logic [6:0] digit7(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    task automatic push_sym(input logic [6:0] s, input logic d, input int f);
        sym_t t;
        t.seg = s;
        t.dp  = d;
        t.fld = 2'(f);
        syms.push_back(t);
    endtask

    // label, sign, tens, ones for one field; saturates to 99 with dp above 99
    task automatic add_field(input int f, input int v);
        int m;
        bit big;
        m   = (v < 0) ? -v : v;
        big = (m > 99);
        push_sym((f == 0) ? 7'h7C : (f == 1) ? 7'h38 : 7'h5E, 1'b0, f);
        push_sym((v < 0) ? 7'h40 : 7'h00, 1'b0, f);
        push_sym(digit7(big ? 9 : m / 10), big, f);
        push_sym(digit7(big ? 9 : m % 10), big, f);
    endtask

    task automatic build(input int ic, input int sl, input int dt, input bit edet);
        syms.delete();
        if (edet) begin
            push_sym(7'h79, 1'b0, 3);
            push_sym(7'h06, 1'b0, 3);
            add_field(2, dt);
        end else begin
            add_field(0, ic);
            add_field(1, sl);
            add_field(2, dt);
        end
    endtask

    task automatic capture(input int ic, input int sl, input int dt, input bit edet);
        intercept    = W'(ic);
        slope        = W'(sl);
        det          = W'(dt);
        error_det    = edet;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        // Scramble inputs: the display must run from the snapshot only.
        intercept    = W'($urandom);
        slope        = W'($urandom);
        det          = W'($urandom);
        error_det    = 1'($urandom_range(0, 1));
        build(ic, sl, dt, edet);
    endtask

    // Expected trace: symbol i shown for D cycles then G blank; frame_done on each wrap.
    task automatic run_cycles(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            int   len;
            int   i;
            int   ph;
            logic fd;
            len = syms.size();
            i   = (c / P) % len;
            ph  = c % P;
            fd  = (c > 0) && (c % (len * P) == 0);
            if (ph < D) check_all($sformatf("%s c%0d", tag, c), syms[i].seg, syms[i].dp,
                                  1'b1, syms[i].fld, fd);
            else check_all($sformatf("%s c%0d", tag, c), 7'h00, 1'b0, 1'b1, syms[i].fld, fd);
            tick();
        end
    endtask

    function automatic int rnd_val();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
        return int'($urandom_range(0, 240)) - 120;
    endfunction

    initial begin
        // 1: reset and idle
        rst = 1'b1;
        tick();
        tick();
        check_all("reset", 7'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check_all($sformatf("idle c%0d", c), 7'h00, 1'b0, 1'b0, 2'd0, 1'b0);
            tick();
        end

        // 2: directed normal snapshot, full frame plus wrap
        capture(7, -23, 150, 1'b0);
        run_cycles("normal", 12 * P + 1);

        // 3: singular-matrix snapshot
        capture(5, 5, 0, 1'b1);
        run_cycles("errdet", 6 * P + 1);

        // 4: most negative slope
        capture(-99, -8192, 100, 1'b0);
        run_cycles("minneg", 12 * P + 1);

        // random snapshots
        for (int k = 0; k < 4; k++) begin
            bit e;
            e = ($urandom_range(0, 3) == 0);
            capture(rnd_val(), rnd_val(), rnd_val(), e);
            run_cycles($sformatf("rand%0d", k), (e ? 6 : 12) * P + 1);
        end

        // 5: restart mid-symbol 5, no frame_done for the aborted frame
        capture(42, 13, -7, 1'b0);
        run_cycles("abort_a", 5 * P + 2);
        capture(rnd_val(), rnd_val(), rnd_val(), 1'b0);
        chk("restart first sym", {1'b0, seg}, 8'h7C);
        run_cycles("abort_b", 12 * P + 1);

        // 6: error_values wins over simultaneous result_valid; ERR is sticky
        intercept    = W'(3);
        error_values = 1'b1;
        result_valid = 1'b1;
        tick();
        error_values = 1'b0;
        result_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            check_all($sformatf("err c%0d", c), ((c / D) % 2 == 1) ? 7'h5B : 7'h79,
                      1'b0, 1'b1, 2'd3, 1'b0);
            result_valid = 1'($urandom_range(0, 1));
            tick();
        end
        result_valid = 1'b0;
        tick();
        // asynchronous reset mid-dwell, checked before the next clock edge
        #2;
        rst = 1'b1;
        #1;
        check_all("async rst", 7'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_all("after rst", 7'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
